image_loader: RTL and testbench

- Upstream feeder for neural_network.
- Receives a framed 28x28 grayscale image as a byte stream from the UART RX block and verifies an 8-bit checksum.
- Buffers the 784 pixels and exposes them to layer-1 matrix multiply through an asynchronous read port as signed 32-bit words.
- Pulses start to the network, waits for done, latches the argmax digit and reports it.

---
 rtl/nn_pkg.sv | 18 +
 rtl/image_loader_if.sv | 25 ++
 rtl/pixel_buffer.sv | 22 ++
 rtl/image_loader.sv | 142 ++++++++++++++
 tb/tb_image_loader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the image_loader -> neural_network front end:
// image geometry, datapath width, frame header byte and loader FSM states.
package nn_pkg;

  localparam int         IMG_DIM    = 28;
  localparam int         NUM_PIXELS = IMG_DIM * IMG_DIM;
  localparam int         DATA_W     = 32;
  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CKSUM,
    S_START,
    S_RUN
  } state_t;

endpackage

// File: rtl/image_loader_if.sv
// Byte stream in, pixel read port and network start/done handshake of image_loader.
// The slave side is the loader; the master side is the UART/mm1/network surroundings.
interface image_loader_if #(
  parameter int DATA_W = nn_pkg::DATA_W
) ();

  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic [15:0]              rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     nn_start;
  logic                     nn_done;
  logic [3:0]               nn_result;

  modport master (
    output rx_data, rx_valid, rd_addr, nn_done, nn_result,
    input  rd_data, nn_start
  );

  modport slave (
    input  rx_data, rx_valid, rd_addr, nn_done, nn_result,
    output rd_data, nn_start
  );

endinterface

// File: rtl/pixel_buffer.sv
// Frame store for one image: one synchronous write port, one asynchronous read port.
module pixel_buffer #(
  parameter int DEPTH = nn_pkg::NUM_PIXELS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/image_loader.sv
// Receives a framed, checksummed 28x28 image over UART, buffers it for layer-1,
// kicks the network and latches its argmax result.
import nn_pkg::state_t;
import nn_pkg::S_IDLE;
import nn_pkg::S_LOAD;
import nn_pkg::S_CKSUM;
import nn_pkg::S_START;
import nn_pkg::S_RUN;

module image_loader #(
  parameter int         NUM_PIXELS     = nn_pkg::NUM_PIXELS,
  parameter logic [7:0] SYNC_BYTE      = nn_pkg::SYNC_BYTE,
  parameter int         PIXEL_SHIFT    = 0,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          reset,
  image_loader_if.slave bus,
  output logic          image_valid,
  output logic          busy,
  output logic [3:0]    result,
  output logic          result_valid,
  output logic          frame_err,
  output logic          overrun
);

  localparam int DATA_W = nn_pkg::DATA_W;
  localparam int AW     = $clog2(NUM_PIXELS);
  localparam int CW     = $clog2(NUM_PIXELS + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    cksum;
  logic [TW-1:0] to_cnt;
  logic [7:0]    buf_rdata;
  logic          sync_hit, last_pixel, timeout_hit, cksum_ok;

  function automatic logic signed [DATA_W-1:0] widen_pixel(input logic [7:0] px);
    logic [DATA_W-1:0] w;
    w = {{(DATA_W-8){1'b0}}, px};
    return signed'(w << PIXEL_SHIFT);
  endfunction

  pixel_buffer #(.DEPTH(NUM_PIXELS), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (bus.rx_valid && state == S_LOAD),
    .waddr (cnt[AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (bus.rd_addr[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Addresses past the frame read as zero rather than aliasing into the buffer.
  assign bus.rd_data = (bus.rd_addr < 16'(NUM_PIXELS)) ? widen_pixel(buf_rdata) : '0;
  assign bus.nn_start = (state == S_START);
  assign busy         = (state != S_IDLE);

  assign sync_hit    = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign last_pixel  = (cnt == CW'(NUM_PIXELS - 1));
  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign cksum_ok    = (bus.rx_data == cksum);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (sync_hit) state_nxt = S_LOAD;
      S_LOAD: begin
        if (bus.rx_valid) begin
          if (last_pixel) state_nxt = S_CKSUM;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_CKSUM: begin
        if (bus.rx_valid)     state_nxt = cksum_ok ? S_START : S_IDLE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_START: state_nxt = S_RUN;
      S_RUN:   if (bus.nn_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cksum        <= '0;
      to_cnt       <= '0;
      image_valid  <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sync_hit) begin
            cnt         <= '0;
            cksum       <= '0;
            to_cnt      <= '0;
            overrun     <= 1'b0;
            image_valid <= 1'b0;
          end
        end
        S_LOAD, S_CKSUM: begin
          // A byte arriving on the expiry cycle still counts and restarts the idle timer.
          if (bus.rx_valid) begin
            to_cnt <= '0;
            if (state == S_LOAD) begin
              cnt   <= cnt + CW'(1);
              cksum <= cksum + bus.rx_data;
            end else if (cksum_ok) begin
              image_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (timeout_hit) begin
            to_cnt      <= '0;
            frame_err   <= 1'b1;
            image_valid <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_RUN: begin
          if (bus.rx_valid) overrun <= 1'b1;
          if (bus.nn_done) begin
            result       <= bus.nn_result;
            result_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed-plus-random bench for image_loader: two instances (pixel shift 0 and 8,
// short idle timeout) share one stimulus stream and are checked against a frame model.
module tb_image_loader;

  localparam int NPIX = nn_pkg::NUM_PIXELS;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  image_loader_if bus0 ();
  image_loader_if bus8 ();

  assign bus8.rx_data   = bus0.rx_data;
  assign bus8.rx_valid  = bus0.rx_valid;
  assign bus8.rd_addr   = bus0.rd_addr;
  assign bus8.nn_done   = bus0.nn_done;
  assign bus8.nn_result = bus0.nn_result;

  logic       iv0, busy0, rv0, ferr0, ovr0;
  logic [3:0] res0;
  logic       iv8, busy8, rv8, ferr8, ovr8;
  logic [3:0] res8;

  image_loader #(.PIXEL_SHIFT(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .image_valid(iv0), .busy(busy0), .result(res0),
    .result_valid(rv0), .frame_err(ferr0), .overrun(ovr0)
  );

  image_loader #(.PIXEL_SHIFT(8), .TIMEOUT_CYCLES(TMO)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8),
    .image_valid(iv8), .busy(busy8), .result(res8),
    .result_valid(rv8), .frame_err(ferr8), .overrun(ovr8)
  );

  int tests = 0;
  int fails = 0;
  int starts0 = 0;

  always @(posedge clk) if (bus0.nn_start) starts0 <= starts0 + 1;

  // Reference model: the image as the bench sent it, plus expected status registers.
  logic [7:0] pix   [NPIX];
  logic [7:0] mem_m [NPIX];
  logic [3:0] exp_res;
  logic       exp_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic iv, input logic b, input logic st,
                                     input logic fe, input logic rv, input logic ov,
                                     input logic [3:0] r);
    return {22'b0, iv, b, st, fe, rv, ov, r};
  endfunction

  task automatic chk_ctl(input string tag, input logic [31:0] e);
    chk({tag, "/sh0"}, {22'b0, iv0, busy0, bus0.nn_start, ferr0, rv0, ovr0, res0}, e);
    chk({tag, "/sh8"}, {22'b0, iv8, busy8, bus8.nn_start, ferr8, rv8, ovr8, res8}, e);
  endtask

  task automatic chk_rd(input logic [15:0] a);
    logic [31:0] e;
    bus0.rd_addr = a;
    #1;
    e = 32'd0;
    if (a < 16'(NPIX)) e = {24'b0, mem_m[a]};
    chk($sformatf("rd_sh0@%0d", a), bus0.rd_data, e);
    chk($sformatf("rd_sh8@%0d", a), bus8.rd_data, e << 8);
  endtask

  function automatic logic [7:0] frame_sum();
    int s = 0;
    for (int i = 0; i < NPIX; i++) s += int'(pix[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) @(negedge clk);
    bus0.rx_data  = b;
    bus0.rx_valid = 1'b1;
    @(negedge clk);
    bus0.rx_valid = 1'b0;
  endtask

  task automatic load_frame(input int n);
    send_byte(8'hA5, $urandom_range(0, 2));
    exp_ovr = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_byte(pix[i], $urandom_range(0, 2));
      mem_m[i] = pix[i];
    end
  endtask

  task automatic run_frame(input string tag, input logic [3:0] res, input bit extra,
                           input int wait_cyc);
    int s0;
    load_frame(NPIX);
    send_byte(frame_sum(), $urandom_range(0, 2));
    s0 = starts0;
    chk_ctl({tag, "_start"}, mk(1, 1, 1, 0, 0, exp_ovr, exp_res));
    @(negedge clk);
    chk({tag, "_one_start"}, starts0, s0 + 1);
    chk_ctl({tag, "_run"}, mk(1, 1, 0, 0, 0, exp_ovr, exp_res));
    if (extra) begin
      send_byte(8'hA5, 0);
      exp_ovr = 1'b1;
      chk_ctl({tag, "_overrun"}, mk(1, 1, 0, 0, 0, 1, exp_res));
    end
    repeat (wait_cyc) @(negedge clk);
    chk_ctl({tag, "_wait"}, mk(1, 1, 0, 0, 0, exp_ovr, exp_res));
    bus0.nn_result = res;
    bus0.nn_done   = 1'b1;
    @(negedge clk);
    bus0.nn_done = 1'b0;
    exp_res = res;
    chk_ctl({tag, "_result"}, mk(1, 0, 0, 0, 1, exp_ovr, exp_res));
    @(negedge clk);
    chk_ctl({tag, "_rv_end"}, mk(1, 0, 0, 0, 0, exp_ovr, exp_res));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: summary not reached within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, pa;
    logic [7:0] bad;
    bus0.rx_data   = 8'h00;
    bus0.rx_valid  = 1'b0;
    bus0.rd_addr   = 16'd0;
    bus0.nn_done   = 1'b0;
    bus0.nn_result = 4'd0;
    exp_res = 4'd0;
    exp_ovr = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_ctl("reset", mk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    @(negedge clk);
    chk_ctl("idle", mk(0, 0, 0, 0, 0, 0, 0));
    send_byte(8'h3C, 0);
    chk_ctl("idle_noise", mk(0, 0, 0, 0, 0, 0, 0));

    // Counting-pattern frame.
    for (int i = 0; i < NPIX; i++) pix[i] = 8'(i % 256);
    run_frame("good", 4'd7, 1'b0, 3);
    chk_rd(16'd300);
    chk("rd300_literal", bus0.rd_data, 32'd44);

    // Same frame, checksum off by one.
    bad = frame_sum() + 8'd1;
    load_frame(NPIX);
    s0 = starts0;
    send_byte(bad, 1);
    chk_ctl("bad_cksum", mk(0, 0, 0, 1, 0, 0, exp_res));
    @(negedge clk);
    chk_ctl("bad_cksum_end", mk(0, 0, 0, 0, 0, 0, exp_res));
    chk("bad_cksum_no_start", starts0, s0);

    bus0.nn_result = 4'hC;
    bus0.nn_done   = 1'b1;
    @(negedge clk);
    bus0.nn_done = 1'b0;
    chk_ctl("done_outside_run", mk(0, 0, 0, 0, 0, 0, exp_res));

    // Timeout: one byte lands exactly on the expiry cycle, then silence.
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    send_byte(8'hA5, 0);
    for (int i = 0; i < 10; i++) begin
      send_byte(pix[i], (i == 3) ? TMO - 1 : int'($urandom_range(0, 2)));
      mem_m[i] = pix[i];
      if (i == 3) chk_ctl("byte_beats_timeout", mk(0, 1, 0, 0, 0, 0, exp_res));
    end
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k == TMO - 1) chk_ctl("timeout_pre", mk(0, 1, 0, 0, 0, 0, exp_res));
      if (k == TMO)     chk_ctl("timeout_hit", mk(0, 0, 0, 1, 0, 0, exp_res));
    end

    // Random frame with a sync-valued pixel and a full-scale pixel; overrun in RUN.
    pa = 100 + int'($urandom_range(0, 600));
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    pix[pa] = 8'hA5;
    pix[5]  = 8'hFF;
    run_frame("rand1", 4'($urandom_range(0, 9)), 1'b1, 150);
    chk_rd(16'(pa));
    chk("sync_as_pixel", bus0.rd_data, 32'd165);
    chk_rd(16'd5);
    chk("shift_full_scale", bus8.rd_data, 32'h0000FF00);
    chk_rd(16'd784);
    chk("out_of_range", bus0.rd_data, 32'd0);
    chk_rd(16'hFFFF);
    for (int i = 0; i < 6; i++) chk_rd(16'($urandom_range(0, NPIX - 1)));

    // Next SYNC clears overrun; reset after 400 pixels.
    send_byte(8'hA5, 0);
    exp_ovr = 1'b0;
    chk_ctl("sync_clears_overrun", mk(0, 1, 0, 0, 0, 0, exp_res));
    for (int i = 0; i < 400; i++) begin
      pix[i] = 8'($urandom);
      send_byte(pix[i], $urandom_range(0, 1));
      mem_m[i] = pix[i];
    end
    reset = 1'b1;
    @(negedge clk);
    exp_res = 4'd0;
    chk_ctl("reset_mid_load", mk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    run_frame("after_reset", 4'($urandom_range(0, 9)), 1'b0, $urandom_range(0, 4));
    for (int i = 0; i < 6; i++) chk_rd(16'($urandom_range(0, NPIX - 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
